// File: rtl/frame_length_stream_arbiter.sv
// rtl/frame_length_stream_arbiter.sv - frame-level round-robin merge of length-prefixed byte streams
module frame_length_stream_arbiter #(
  parameter int NUM_PORTS   = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int GRANT_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [GRANT_WIDTH-1:0]          grant_index,
  output logic                            busy
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                 state_q;
  logic [GRANT_WIDTH-1:0] grant_q;
  logic [GRANT_WIDTH-1:0] last_grant_q;
  logic                   busy_q;

  logic [GRANT_WIDTH-1:0] pick_d;
  logic                   pick_valid_d;
  logic [GRANT_WIDTH-1:0] scan_idx;
  logic                   frame_done;

  // Round-robin scan starting just after the last served port; first requester wins.
  always_comb begin
    pick_d       = '0;
    pick_valid_d = 1'b0;
    scan_idx     = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      scan_idx = GRANT_WIDTH'((int'(last_grant_q) + k) % NUM_PORTS);
      if (!pick_valid_d && s_axis_tvalid[scan_idx]) begin
        pick_d       = scan_idx;
        pick_valid_d = 1'b1;
      end
    end
  end

  // The frame ends on the handshake of its tlast beat.
  assign frame_done = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  // Arbitration FSM: IDLE picks a port, BUSY holds it until the frame's last beat is accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GRANT_WIDTH'(NUM_PORTS - 1);
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid_d) begin
            grant_q <= pick_d;
            state_q <= BUSY;
            busy_q  <= 1'b1;
          end
        end
        BUSY: begin
          if (frame_done) begin
            last_grant_q <= grant_q;
            state_q      <= IDLE;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Zero-latency pass-through of the granted port; everything quiet while not locked.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (busy_q) begin
      m_axis_tdata           = s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
      m_axis_tvalid          = s_axis_tvalid[grant_q];
      m_axis_tlast           = s_axis_tlast[grant_q];
      s_axis_tready[grant_q] = m_axis_tready;
    end
  end

  assign grant_index = grant_q;
  assign busy        = busy_q;

endmodule
